alu_seq: RTL and testbench

Parametrised, handshaked successor to the 32-bit combinational ALU. It keeps the existing op encodings and flags and adds iterative multiply and divide. Each operation has registered outputs and a valid/ready handshake on both sides. It sits between the decode/issue stage and writeback, and stalls the issue stage while a multi-cycle op runs.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/shifter_n.sv | 47 ++++
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_NONE = 2'b11
    } sh_ctrl_t;

    // The whole 11xx block is the iterative mul/div group.
    function automatic logic is_iterative(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/shifter_n.sv
// Purpose: log-stage barrel shifter, ctrl 00=SLL 01=SRL 10=SRA, other codes give 0.
// Latency: purely combinational.
// Backpressure: none, no state.
module shifter_n #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] din_rev;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] stage_rev;
    logic             fill;

    // Left shifts reuse the right-shift stages on a bit-reversed operand.
    always_comb begin
        din_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            din_rev[i] = din[WIDTH-1-i];
        end
    end

    assign fill = (ctrl == 2'b10) && din[WIDTH-1];

    always_comb begin
        stage = (ctrl == 2'b00) ? din_rev : din;
        for (int s = 0; s < SHW; s++) begin
            if (shamt[s]) begin
                stage = fill ? ~(~stage >> (1 << s)) : (stage >> (1 << s));
            end
        end
        stage_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            stage_rev[i] = stage[WIDTH-1-i];
        end
        case (ctrl)
            2'b00:        dout = stage_rev;
            2'b01, 2'b10: dout = stage;
            default:      dout = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Purpose: handshaked ALU with single-cycle logic/arith/shift ops and iterative mul/div.
// Latency: single-cycle ops valid the cycle after accept; mul/div valid WIDTH+1 cycles after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               iter_last;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]     cnt;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic               sub_ovf;
    logic [1:0]         sh_ctrl;
    logic [WIDTH-1:0]   sh_out;
    logic [WIDTH-1:0]   one_res;
    logic               one_cout;

    logic [WIDTH:0]     mul_hi;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   fin_res;

    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               cout_q;

    assign accept    = in_valid && in_ready;
    assign iter_last = (cnt == SHW'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = is_iterative(op) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (iter_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign sub_ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (sub_sum[WIDTH-1] ^ a[WIDTH-1]);

    always_comb begin
        case (op)
            OP_SLL:  sh_ctrl = SH_SLL;
            OP_SRL:  sh_ctrl = SH_SRL;
            OP_SRA:  sh_ctrl = SH_SRA;
            default: sh_ctrl = SH_NONE;
        endcase
    end

    shifter_n #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .din   (a),
        .shamt (b[SHW-1:0]),
        .ctrl  (sh_ctrl),
        .dout  (sh_out)
    );

    always_comb begin
        one_res  = '0;
        one_cout = 1'b0;
        case (op)
            OP_AND: one_res = a & b;
            OP_OR:  one_res = a | b;
            OP_XOR: one_res = a ^ b;
            OP_ADD: begin
                one_res  = add_sum[WIDTH-1:0];
                one_cout = add_sum[WIDTH];
            end
            OP_SUB: begin
                one_res  = sub_sum[WIDTH-1:0];
                one_cout = sub_sum[WIDTH];
            end
            OP_SLT: begin
                one_res  = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
                one_cout = sub_sum[WIDTH];
            end
            OP_SLL, OP_SRL, OP_SRA: one_res = sh_out;
            default: begin
                one_res  = '0;
                one_cout = 1'b0;
            end
        endcase
    end

    // acc = {hi, lo}: hi is the partial product / running remainder,
    // lo the multiplier bits still to consume / dividend becoming quotient.
    assign mul_hi    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};

    always_comb begin
        if (op_q[1] == 1'b0) begin
            acc_nxt = {mul_hi, acc[WIDTH-1:1]};
        end else if (div_trial[WIDTH]) begin
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // MULHU and REMU take the high half, MUL and DIVU the low half.
    assign fin_res = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            opb_q    <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            opb_q <= b;
            acc   <= {{WIDTH{1'b0}}, a};
            cnt   <= '0;
            if (!is_iterative(op)) begin
                result_q <= one_res;
                zero_q   <= (one_res == '0);
                cout_q   <= one_cout;
            end
        end else if (state == ST_BUSY) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (iter_last) begin
                result_q <= fin_res;
                zero_q   <= (fin_res == '0);
                cout_q   <= 1'b0;
            end
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [3:0]   op        = '0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;

    int tests = 0;
    int fails = 0;

    logic [W:0]   exp_q[$];
    logic [W:0]   e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] held;
    logic [3:0]   ro;
    logic [3:0]   singles[9];
    int           nres;
    int           bad;
    logic         was_acc;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: {cout, result} from plain arithmetic on the op's meaning.
    function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] p, input logic [W-1:0] q);
        logic [2*W-1:0] prod;
        logic [W:0]     s;
        prod = {{W{1'b0}}, p} * {{W{1'b0}}, q};
        case (o)
            4'b0000: return {1'b0, p & q};
            4'b0001: return {1'b0, p | q};
            4'b0010: begin s = {1'b0, p} + {1'b0, q}; return s; end
            4'b0100: return {1'b0, p ^ q};
            4'b0110: return {(p >= q), p - q};
            4'b0111: return {(p >= q), ($signed(p) < $signed(q)) ? W'(1) : W'(0)};
            4'b1000: return {1'b0, p << q[4:0]};
            4'b1001: return {1'b0, p >> q[4:0]};
            4'b1010: return {1'b0, W'($signed(p) >>> q[4:0])};
            4'b1100: return {1'b0, prod[W-1:0]};
            4'b1101: return {1'b0, prod[2*W-1:W]};
            4'b1110: return {1'b0, (q == 0) ? {W{1'b1}} : p / q};
            4'b1111: return {1'b0, (q == 0) ? p : p % q};
            default: return '0;
        endcase
    endfunction

    // Issue one request from IDLE, check latency and the result; release unless hold.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] p,
                          input logic [W-1:0] q, input logic [W-1:0] er, input logic ec,
                          input bit hold);
        int busy_bad;
        check({tag, ".in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        op = o; a = p; b = q;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom;
        if (o >= 4'hC) begin
            busy_bad = 0;
            repeat (W) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0) busy_bad++;
                @(posedge clk); #1;
            end
            check({tag, ".busy_cycles"}, W'(busy_bad), W'(0));
        end
        check({tag, ".out_valid"}, W'(out_valid), W'(1));
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, W'(zero), W'(er == '0));
        check({tag, ".cout"}, W'(cout), W'(ec));
        if (!hold) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, ".released"}, W'(out_valid), W'(0));
        end
    endtask

    initial begin
        singles = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", W'(out_valid), W'(0));
        check("rst.in_ready", W'(in_ready), W'(1));
        check("rst.result", result, W'(0));
        check("rst.zero", W'(zero), W'(0));
        check("rst.cout", W'(cout), W'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single-cycle ops
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 0);
        run_op("sub_neg", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("slt_min", OP_SLT, 32'h8000_0000, 32'h1, 32'h1, 1'b1, 0);
        run_op("slt_max", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 0);
        run_op("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("srl31", OP_SRL, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 0);
        run_op("sll4", OP_SLL, 32'h8000_00F1, 32'd4, 32'h0000_0F10, 1'b0, 0);
        run_op("undef", 4'b0011, 32'h1234, 32'h5678, 32'h0, 1'b0, 0);

        // Directed iterative ops
        run_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
        run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 0);
        run_op("divu_by0", OP_DIVU, $urandom, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("remu_by0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1'b0, 0);

        // Backpressure: result must hold for 5 stalled cycles
        run_op("bp_mul", OP_MUL, 32'd123457, 32'd1000, 32'd123457000, 1'b0, 1);
        held = 32'd123457000;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("bp.stall_cycles", W'(bad), W'(0));
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ADD; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        check("bp.no_accept_on_release", W'(out_valid), W'(0));
        check("bp.in_ready_after", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.next_valid", W'(out_valid), W'(1));
        check("bp.next_result", result, W'(7));
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Back-to-back single-cycle ops, out_ready tied high
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = singles[$urandom_range(0, 8)]; a = $urandom; b = $urandom;
        nres = 0;
        for (int i = 0; i < 20; i++) begin
            was_acc = in_ready;
            @(posedge clk); #1;
            if (was_acc) begin
                exp_q.push_back(model(op, a, b));
                op = singles[$urandom_range(0, 8)]; a = $urandom; b = $urandom;
            end
            if (out_valid) begin
                nres++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b.result", result, e[W-1:0]);
                    check("b2b.cout", W'(cout), W'(e[W]));
                end
            end
            if (i == 18) in_valid = 1'b0;
        end
        check("b2b.count", W'(nres), W'(10));
        out_ready = 1'b0;

        // Random ops of every code against the model
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom);
            x = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 300)) : $urandom;
            y = ($urandom_range(0, 6) == 0) ? W'(0) : $urandom;
            if ($urandom_range(0, 3) == 0) y = W'($urandom_range(1, 40));
            e = model(ro, x, y);
            run_op($sformatf("rand%0d_op%0h", i, ro), ro, x, y, e[W-1:0], e[W], 0);
        end

        // Reset in the middle of a divide
        in_valid = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", W'(out_valid), W'(0));
        check("midrst.in_ready", W'(in_ready), W'(1));
        check("midrst.result", result, W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst.idle_out_valid", W'(out_valid), W'(0));
        run_op("post_rst_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
